// File: rtl/parity_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_sched_pkg
// Description : Shared definitions for the parity scheduler: FSM state
//               encoding and the odd-result counter ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturation value of the odd-result statistics counter
  localparam logic [7:0] STAT_MAX = 8'd255;

endpackage : parity_sched_pkg
`default_nettype wire

// File: rtl/calc_parity.sv
`default_nettype none
// ============================================================================
// Module      : calc_parity
// Description : XOR reduction of a data word; parity=1 when the word holds
//               an odd number of ones.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_parity #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  output logic         parity
);

  assign parity = ^a;

endmodule : calc_parity
`default_nettype wire

// File: rtl/parity_sched.sv
`default_nettype none
// ============================================================================
// Module      : parity_sched
// Description : Round-robin scheduler sharing one parity unit between NREQ
//               requesters. Each transaction takes three cycles:
//               latch (IDLE) -> compute (CALC) -> complete (DONE), with the
//               one-hot ack and the result appearing as registered outputs
//               in the cycle after the DONE edge.
//               Optional feature macro: PARITY_STATS_EN adds an 8-bit
//               saturating odd-result counter on port stat_odd_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_sched
  import parity_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*DW-1:0]            din,
  output logic [NREQ-1:0]               ack,
  output logic                          parity_out,
  output logic [$clog2(NREQ)-1:0]       grant_id,
  output logic                          busy
`ifdef PARITY_STATS_EN
  ,
  output logic [7:0]                    stat_odd_cnt
`endif
);

  localparam int GW = $clog2(NREQ);
  localparam logic [NREQ-1:0] c_ONE = NREQ'(1);

  state_t          r_state;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_last;
  logic [DW-1:0]   r_data;
  logic            r_parity;
  logic [NREQ-1:0] r_ack;
  logic            r_par_out;
  logic            r_busy;
`ifdef PARITY_STATS_EN
  logic [7:0]      r_odd_cnt;
`endif

  logic [GW-1:0]   w_win;
  logic [GW-1:0]   w_idx;
  logic            w_hit;
  logic [DW-1:0]   w_byte;
  logic            w_parity;

  // Round-robin winner: first requester found scanning from last grant + 1
  always_comb begin
    w_win = '0;
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = GW'((int'(r_last) + k) % NREQ);
      if (!w_hit && req[w_idx]) begin
        w_win = w_idx;
        w_hit = 1'b1;
      end
    end
  end

  // Select the winner's byte from the packed request bus
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == GW'(i)) begin
        w_byte = din[i*DW +: DW];
      end
    end
  end

  calc_parity #(
    .W      (DW)
  ) u_calc_parity (
    .a      (r_data),
    .parity (w_parity)
  );

  // Scheduler FSM with registered outputs; ack/parity default low each cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= GW'(NREQ - 1);
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_ack     <= '0;
      r_par_out <= 1'b0;
      r_busy    <= 1'b0;
`ifdef PARITY_STATS_EN
      r_odd_cnt <= '0;
`endif
    end else begin
      r_ack     <= '0;
      r_par_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_grant <= w_win;
            r_data  <= w_byte;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_parity <= w_parity;
          r_state  <= DONE;
        end
        DONE: begin
          r_ack     <= c_ONE << r_grant;
          r_par_out <= r_parity;
          r_last    <= r_grant;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
`ifdef PARITY_STATS_EN
          if (r_parity && (r_odd_cnt != STAT_MAX)) begin
            r_odd_cnt <= r_odd_cnt + 8'd1;
          end
`endif
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack          = r_ack;
  assign parity_out   = r_par_out;
  assign grant_id     = r_grant;
  assign busy         = r_busy;
`ifdef PARITY_STATS_EN
  assign stat_odd_cnt = r_odd_cnt;
`endif

endmodule : parity_sched
`default_nettype wire

// File: tb/tb_parity_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_sched
// Description : Scoreboard bench for parity_sched. A transaction-level model
//               predicts each grant, its byte's parity and the cycle its ack
//               is due; a negedge monitor pops and compares. Directed
//               scenarios are followed by a randomized phase.
//               Honours PARITY_STATS_EN for the statistics counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int GW   = $clog2(NREQ);

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*DW-1:0]     din;
  logic [NREQ-1:0]        ack;
  logic                   parity_out;
  logic [GW-1:0]          grant_id;
  logic                   busy;
`ifdef PARITY_STATS_EN
  logic [7:0]             stat_odd_cnt;
`endif

  parity_sched #(
    .NREQ         (NREQ),
    .DW           (DW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .din          (din),
    .ack          (ack),
    .parity_out   (parity_out),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef PARITY_STATS_EN
    ,
    .stat_odd_cnt (stat_odd_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int win;
    bit par;
  } exp_t;

  exp_t            q[$];
  int              ecount   = 0;
  int              nchk     = 0;
  int              npass    = 0;
  int              last_g   = NREQ - 1;
  int              next_arb = 0;
  int              busy_s   = -1;
  int              busy_e   = -2;
  logic [NREQ-1:0] granted  = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
  endfunction

  // Transaction-level reference: evaluated with the inputs the DUT just sampled
  task automatic model_edge();
    int         w;
    int         i;
    logic [7:0] b;
    if (!reset_n) begin
      q.delete();
      last_g   = NREQ - 1;
      next_arb = ecount + 1;
      busy_s   = -1;
      busy_e   = -2;
      granted  = '0;
    end else if (ecount >= next_arb) begin
      granted = '0;
      if (|req) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          i = (last_g + k) % NREQ;
          if (w < 0 && req[i]) w = i;
        end
        b = din[w*8 +: 8];
        q.push_back('{due: ecount + 2, win: w, par: bit'($countones(b) % 2)});
        last_g     = w;
        granted[w] = 1'b1;
        busy_s     = ecount;
        busy_e     = ecount + 1;
        next_arb   = ecount + 3;
      end else begin
        next_arb = ecount + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ecount++;
    model_edge();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  // Monitor: compare against the scoreboard in the middle of each cycle
  always @(negedge clk) begin
    exp_t            e;
    logic [NREQ-1:0] oh;
    if (ecount > 0) begin
      if (q.size() > 0 && q[0].due == ecount) begin
        e = q.pop_front();
        oh = '0;
        oh[e.win] = 1'b1;
        chk("ack", 32'(ack), 32'(oh));
        chk("grant_id", 32'(grant_id), 32'(e.win));
        chk("parity_out", 32'(parity_out), 32'(e.par));
      end else begin
        chk("idle_ack", 32'(ack), 32'd0);
        chk("idle_parity", 32'(parity_out), 32'd0);
      end
      chk("busy", 32'(busy), 32'((ecount >= busy_s && ecount <= busy_e) ? 1 : 0));
    end
  end

  initial begin
    reset_n = 1'b0;
    req     = '0;
    din     = '0;

    // Reset held two cycles, then released
    ticks(2);
    reset_n = 1'b1;
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_parity", 32'(parity_out), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);

    // Single request, byte 0xA8; din scrambled after the latch edge
    req = 4'b0001;
    din = 32'h000000A8;
    tick();
    din = 32'($urandom);
    ticks(2);
    req = '0;
    ticks(3);

    // Full contention from a fresh reset: grants 0,1,2,3,0
    reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    req = 4'b1111;
    din = 32'h07030100;
    ticks(13);
    req = '0;
    ticks(4);

    // Early drop: requester 2 releases req before the CALC edge
    req = 4'b0100;
    din = 32'h00FF0000;
    tick();
    req = '0;
    ticks(4);

    // Reset during CALC aborts; then requester 1 with 0x80
    req = 4'b1000;
    din = 32'h55000000;
    tick();
    reset_n = 1'b0;
    req = '0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    reset_n = 1'b1;
    ticks(3);
    req = 4'b0010;
    din = 32'h00008000;
    ticks(3);
    req = '0;
    ticks(3);

`ifdef PARITY_STATS_EN
    // Odd-result counter saturates and clears on reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req = 4'b0001;
    din = 32'h01010101;
    ticks(902);
    req = '0;
    ticks(4);
    chk("stat_sat", 32'(stat_odd_cnt), 32'd255);
    reset_n = 1'b0;
    tick();
    chk("stat_rst", 32'(stat_odd_cnt), 32'd0);
    reset_n = 1'b1;
    tick();
`endif

    // Randomized traffic with early drops, re-requests and rare resets
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!req[r]) begin
          if ($urandom_range(3) == 0) req[r] = 1'b1;
        end else if (granted[r]) begin
          if ($urandom_range(1) == 0) req[r] = 1'b0;
        end
        din[r*8 +: 8] = 8'($urandom);
      end
      reset_n = ($urandom_range(199) != 0);
      tick();
    end

    // Drain outstanding transactions within a bounded number of cycles
    reset_n = 1'b1;
    req = '0;
    for (int c = 0; c < 10 && q.size() > 0; c++) tick();
    tick();
    chk("drain", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule : tb_parity_sched
`default_nettype wire

// File: doc/parity_sched.md
PARITY_SCHED -- requirements
Module: parity_sched

Interface
REQ-001 SHALL provide parameter: NREQ, 4, number of requesters sharing the parity unit (2..8).
REQ-002 SHALL provide parameter: DW, 8, data width per requester; fixed at 8.
REQ-003 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port: reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL provide port: req  input  NREQ  level request per requester, held until its ack.
REQ-006 SHALL provide port: din  input  NREQ*8  request bytes; requester i at din[8i+7:8i].
REQ-007 SHALL provide port: ack  output  NREQ  one-hot, one-cycle completion pulse.
REQ-008 SHALL provide port: parity_out  output  1  result; valid only while ack is nonzero.
REQ-009 SHALL provide port: grant_id  output  clog2(NREQ)  index of the requester being served.
REQ-010 SHALL provide port: busy  output  1  high in every state except IDLE.
REQ-011 SHALL provide port: stat_odd_cnt  output  8  odd-result counter; present only under PARITY_STATS_EN.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-013 IDLE: SHALL stay while req==0; on any req bit set, SHALL pick the winner, latch its byte into data_reg, load grant_id, and go to CALC.
REQ-014 Arbitration SHALL be round-robin: search starts at last_grant+1 and wraps modulo NREQ.
REQ-015 CALC: SHALL register parity_reg = XOR-reduction of data_reg (1 when the byte has an odd count of ones), then go to DONE.
REQ-016 DONE: SHALL assert ack[grant_id]=1 and drive parity_out=parity_reg for exactly one cycle, set last_grant=grant_id, and go to IDLE.
REQ-017 Latency SHALL be fixed: req sampled in IDLE at edge t gives ack high in the cycle after edge t+2, i.e. 3 cycles per transaction with no back-to-back overlap.
REQ-018 din changes after the latch edge SHALL NOT affect the result.
REQ-019 If the winner drops req during CALC or DONE, the transaction SHALL still complete with its ack.
REQ-020 A req bit still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-021 Requests arriving while busy SHALL wait; none SHALL be lost while held high.
REQ-022 Outside DONE, ack SHALL be 0 and parity_out SHALL be 0.

Reset
REQ-023 When reset_n is low at a clock edge, the block SHALL set: FSM to IDLE, ack=0, parity_out=0, grant_id=0, busy=0, data_reg=0, parity_reg=0, last_grant=NREQ-1 (requester 0 wins first), and stat_odd_cnt=0.
REQ-024 Reset asserted mid-transaction SHALL abort the transaction with no ack pulse.

Configuration
REQ-025 Macro PARITY_STATS_EN defined: an 8-bit counter SHALL increment on each DONE with parity_reg=1, saturate at 255, and drive stat_odd_cnt.
REQ-026 Macro PARITY_STATS_EN undefined: the counter logic and the stat_odd_cnt port SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the constant STAT_MAX=8'd255.
REQ-028 The XOR reduction SHALL be a single instance of the existing calc_parity sub-module (ports a, parity) driven by data_reg.
REQ-029 The round-robin winner logic SHALL stay inside parity_sched as combinational logic.

Verification
REQ-030 Reset: hold reset_n=0 for 2 cycles, then release -> ack=0, busy=0, parity_out=0, grant_id=0.
REQ-031 Single request: req=4'b0001, byte0=8'hA8 -> ack=4'b0001 three cycles later, parity_out=1.
REQ-032 Full contention: req=4'b1111 held, bytes 8'h00/8'h01/8'h03/8'h07 -> grants 0,1,2,3,0; parity 0,1,0,1,0.
REQ-033 Early drop: req[2] with byte 8'hFF, dropped during CALC -> ack[2] still pulses, parity_out=0.
REQ-034 Mid-operation reset: reset_n=0 during CALC -> IDLE next cycle and no ack; a following req[1] with 8'h80 -> ack[1], parity_out=1.
REQ-035 With PARITY_STATS_EN: 300 transactions of byte 8'h01 -> stat_odd_cnt=255; a reset -> stat_odd_cnt=0.
